mlc_capture_writer: RTL and testbench
=====================================

# mlc_capture_writer

Capture-data write stage directly downstream of the MALICMATA controller. It accepts 64-bit capture words over the `mlc_data` / `mlc_data_valid` / `ddr3_ack` handshake and buffers them in an internal FIFO. It groups them into bursts and issues each burst to the DDR3 write port as an address/length command followed by a data beat stream. A flush, driven from `cap_done`, drains any partial burst and ends the frame with a `done` pulse.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in words; power of 2, and at least `BURST`.
- `BURST`, 8: words per full burst; power of 2, at most 16.
- `ADDR_W`, 27: DDR3 byte-address width.
- `BASE_ADDR`, 0: frame start address.
- `ADDR_STEP`, 8: bytes per word.

Ports:
- `sys_clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  one-cycle pulse that arms a new frame.
- `flush`  in  1  one-cycle pulse, end of capture; driven from `cap_done`.
- `mlc_data`  in  64  capture word.
- `mlc_data_valid`  in  1  word present; held until acknowledged.
- `ddr3_ack`  out  1  word accepted this cycle.
- `cmd_valid`  out  1  burst command valid.
- `cmd_ready`  in  1  DDR3 port accepts the command.
- `cmd_addr`  out  ADDR_W  burst start byte address.
- `cmd_len`  out  5  words in the burst, 1..`BURST`.
- `wdata`  out  64  write data beat.
- `wdata_valid`  out  1  beat valid.
- `wdata_ready`  in  1  DDR3 port accepts the beat.
- `wdata_last`  out  1  final beat of the burst.
- `busy`  out  1  frame in progress, i.e. state is not IDLE.
- `done`  out  1  one-cycle pulse when the frame has fully drained.
- `word_count`  out  32  words accepted since the last `start`.

## Operation
FSM states: IDLE, COLLECT, CMD, DATA, DONE.

- **IDLE**
  - `start` → COLLECT. This loads `addr` = `BASE_ADDR`, clears `word_count`, and clears `flush_pend`.
  - `flush` is ignored in IDLE.
- **COLLECT**
  - FIFO count ≥ `BURST` → CMD, with `len` = `BURST`.
  - Otherwise, if `flush_pend` is set and count > 0 → CMD, with `len` = count.
  - Otherwise, if `flush_pend` is set and count = 0 → DONE.
- **CMD**
  - `cmd_valid` = 1, with `cmd_addr` and `cmd_len` held stable.
  - `cmd_valid && cmd_ready` → DATA.
- **DATA**
  - `wdata_valid` = 1 and `wdata` = FIFO head.
  - Each `wdata_valid && wdata_ready` pops one word.
  - `wdata_last` = 1 on beat `len`.
  - When the last beat is accepted: `addr` += `len`·`ADDR_STEP` (modulo 2^`ADDR_W`), then → COLLECT.
- **DONE**
  - `done` = 1 for one cycle, then → IDLE.

Acceptance:
- `ddr3_ack` = `mlc_data_valid` & !full & accepting. It is combinational.
- accepting = state ∈ {COLLECT, CMD, DATA} & !`flush_pend`.
- When `ddr3_ack` = 1, the word is written to the FIFO and `word_count` increments (wraps at 2^32). The upstream presents its next word in the following cycle.
- Push and pop proceed independently in all active states.
- `flush` in an active state sets `flush_pend`. From that cycle onward no further words are acknowledged.

Boundary rules:
- `start` while `busy` is ignored.
- `start` and `flush` in the same cycle while in IDLE: `start` wins and `flush` is dropped.
- `full` reflects the pre-cycle count, so there is no push-through when full, even if a pop occurs in the same cycle.
- A `len` computed from count never exceeds the FIFO contents. A DATA beat is never presented while the FIFO is empty.
- `rst` mid-operation: FIFO is emptied, state → IDLE, and any DDR3 transaction is abandoned.

## Timing
Reset values:
- All outputs are 0: `ddr3_ack`, `cmd_valid`, `wdata_valid`, `wdata_last`, `busy`, `done`, `cmd_addr`, `cmd_len`, `wdata`, `word_count`.
- Internal `addr` is reset to `BASE_ADDR`.

Latencies:
- `busy` rises in the cycle after `start`.
- The `BURST`-th word accepted in cycle N → `cmd_valid` in cycle N+1.
- A command accepted in cycle M → first `wdata_valid` in cycle M+1.
- With both readies held at 1, one beat transfers per cycle, and the next burst's `cmd_valid` is no earlier than 2 cycles after the last beat.
- `flush` in cycle F with the FIFO empty and state COLLECT → `done` in cycle F+2, and `busy` = 0 in cycle F+3.

Sustained rate: the FIFO accepts one word per cycle as long as it is not full.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs are 0 immediately and stay 0 after release until `start`.
- **Single full burst:** `start`, then 8 back-to-back words 0x0..0x7, with `cmd_ready` = `wdata_ready` = 1 → one command with `cmd_addr` = 0x0 and `cmd_len` = 8, 8 beats in order, `wdata_last` on 0x7, and `word_count` = 8. Then `flush` → next burst would be at address 0x40, and a `done` pulse follows.
- **Backpressure:** `wdata_ready` = 0 and `mlc_data_valid` held at 1 → exactly 16 acks, then `ddr3_ack` = 0. Release `wdata_ready` → acks resume one cycle after the first pop.
- **Partial flush:** 3 words, then `flush`, while valid stays high → no further acks, one command with `cmd_len` = 3 and `wdata_last` on the 3rd beat, then `done`, then `busy` = 0.
- **Address wrap:** `BASE_ADDR` = 2^27−0x40 with 16 words → commands at 2^27−0x40 and 0x0.
- **Reset mid-burst:** `rst` asserted during DATA beat 4 → state IDLE, and a subsequent `start` plus 8 words produces a clean burst at `BASE_ADDR`.

Source files
------------

// File: rtl/mlc_capture_writer_if.sv
// rtl/mlc_capture_writer_if.sv - capture, control and DDR3 write-port signals of the capture writer
interface mlc_capture_writer_if #(
  parameter int ADDR_W = 27
);
  logic              start;
  logic              flush;
  logic [63:0]       mlc_data;
  logic              mlc_data_valid;
  logic              ddr3_ack;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [4:0]        cmd_len;
  logic [63:0]       wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic              wdata_last;
  logic              busy;
  logic              done;
  logic [31:0]       word_count;

  modport master (
    output start, flush, mlc_data, mlc_data_valid, cmd_ready, wdata_ready,
    input  ddr3_ack, cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid,
    input  wdata_last, busy, done, word_count
  );

  modport slave (
    input  start, flush, mlc_data, mlc_data_valid, cmd_ready, wdata_ready,
    output ddr3_ack, cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid,
    output wdata_last, busy, done, word_count
  );
endinterface

// File: rtl/mlc_capture_writer.sv
// rtl/mlc_capture_writer.sv - buffers capture words in a FIFO and writes them to DDR3 as address/length bursts
module mlc_capture_writer #(
  parameter int                DEPTH     = 16,
  parameter int                BURST     = 8,
  parameter int                ADDR_W    = 27,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  mlc_capture_writer_if.slave  bus
);
  localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_COUNT = CW'(BURST);
  localparam logic [4:0]    BURST_LEN   = 5'(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [63:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_flush_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [4:0]        r_cmd_len;
  logic [4:0]        r_beat;
  logic              r_cmd_valid;
  logic              r_wdata_valid;
  logic              r_wdata_last;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_word_count;

  logic              w_active;
  logic              w_accepting;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_next;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_active     = (r_state == S_COLLECT) || (r_state == S_CMD) || (r_state == S_DATA);
  assign w_accepting  = w_active && !r_flush_pend;
  // Full is judged on the count at the start of the cycle; a same-cycle pop does not open a slot.
  assign w_full       = (r_count == FULL_COUNT);
  assign w_push       = bus.mlc_data_valid && !w_full && w_accepting;
  assign w_pop        = r_wdata_valid && bus.wdata_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_addr_inc   = ADDR_W'(r_cmd_len) * ADDR_W'(ADDR_STEP);

  assign bus.ddr3_ack    = w_push;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_addr    = r_cmd_addr;
  assign bus.cmd_len     = r_cmd_len;
  assign bus.wdata       = r_wdata_valid ? r_mem[r_rd_ptr] : 64'd0;
  assign bus.wdata_valid = r_wdata_valid;
  assign bus.wdata_last  = r_wdata_last;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.word_count  = r_word_count;

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.mlc_data;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_flush_pend  <= 1'b0;
      r_addr        <= BASE_ADDR;
      r_cmd_addr    <= '0;
      r_cmd_len     <= '0;
      r_beat        <= '0;
      r_cmd_valid   <= 1'b0;
      r_wdata_valid <= 1'b0;
      r_wdata_last  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_word_count  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_push) begin
        r_word_count <= r_word_count + 32'd1;
      end
      if (w_active && bus.flush) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_COLLECT;
            r_busy       <= 1'b1;
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_flush_pend <= 1'b0;
          end
        end

        // Decisions use the post-push count so a burst is commanded the cycle after its last word lands.
        S_COLLECT: begin
          if (w_count_next >= BURST_COUNT) begin
            r_state     <= S_CMD;
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= r_addr;
            r_cmd_len   <= BURST_LEN;
          end else if (r_flush_pend && (w_count_next != '0)) begin
            r_state     <= S_CMD;
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= r_addr;
            r_cmd_len   <= 5'(w_count_next);
          end else if (r_flush_pend) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        S_CMD: begin
          if (bus.cmd_ready) begin
            r_state       <= S_DATA;
            r_cmd_valid   <= 1'b0;
            r_wdata_valid <= 1'b1;
            r_wdata_last  <= (r_cmd_len == 5'd1);
            r_beat        <= '0;
          end
        end

        S_DATA: begin
          if (w_pop) begin
            if (r_wdata_last) begin
              r_state       <= S_COLLECT;
              r_wdata_valid <= 1'b0;
              r_wdata_last  <= 1'b0;
              r_addr        <= r_addr + w_addr_inc;
            end else begin
              r_beat       <= r_beat + 5'd1;
              r_wdata_last <= ((r_beat + 5'd2) == r_cmd_len);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mlc_capture_writer.sv
// tb/tb_mlc_capture_writer.sv - directed bench for mlc_capture_writer with a burst/beat transaction model
module tb_mlc_capture_writer;
  localparam logic [26:0] B_BASE = 27'h7FFFFC0;

  logic        sys_clk     = 1'b0;
  logic        rst         = 1'b1;
  logic        start       = 1'b0;
  logic        flush       = 1'b0;
  logic        valid       = 1'b0;
  logic [63:0] data        = '0;
  logic        cmd_ready   = 1'b1;
  logic        wdata_ready = 1'b1;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] eca[$];
  logic [31:0] ecb[$];
  logic [64:0] eba[$];
  logic [64:0] ebb[$];
  logic [31:0] e_cmd;
  logic [64:0] e_beat;
  logic [63:0] tag;
  int          sent;

  mlc_capture_writer_if #(.ADDR_W(27)) ifa ();
  mlc_capture_writer_if #(.ADDR_W(27)) ifb ();

  assign ifa.start          = start;
  assign ifa.flush          = flush;
  assign ifa.mlc_data       = data;
  assign ifa.mlc_data_valid = valid;
  assign ifa.cmd_ready      = cmd_ready;
  assign ifa.wdata_ready    = wdata_ready;
  assign ifb.start          = start;
  assign ifb.flush          = flush;
  assign ifb.mlc_data       = data;
  assign ifb.mlc_data_valid = valid;
  assign ifb.cmd_ready      = cmd_ready;
  assign ifb.wdata_ready    = wdata_ready;

  mlc_capture_writer #(
    .DEPTH(16), .BURST(8), .ADDR_W(27), .BASE_ADDR(27'h0), .ADDR_STEP(8)
  ) u_dut (
    .sys_clk(sys_clk), .rst(rst), .bus(ifa)
  );

  mlc_capture_writer #(
    .DEPTH(16), .BURST(8), .ADDR_W(27), .BASE_ADDR(B_BASE), .ADDR_STEP(8)
  ) u_wrap (
    .sys_clk(sys_clk), .rst(rst), .bus(ifb)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // A frame of n words is cut into 8-word bursts from the head, remainder last; each burst advances 64 bytes.
  task automatic model_frame(input int n, input logic [63:0] t);
    int k;
    int chunk;
    int len;
    logic [26:0] off;
    k = 0;
    chunk = 0;
    while (k < n) begin
      len = (n - k >= 8) ? 8 : (n - k);
      off = 27'(chunk * 64);
      eca.push_back({5'(len), off});
      ecb.push_back({5'(len), B_BASE + off});
      for (int j = 0; j < len; j++) begin
        eba.push_back({(j == len - 1), t + 64'(k + j)});
        ebb.push_back({(j == len - 1), t + 64'(k + j)});
      end
      k += len;
      chunk++;
    end
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (ifa.cmd_valid && ifa.cmd_ready) begin
        if (eca.size() == 0) check("cmd_a_unexpected", 1'b1, 1'b0);
        else begin
          e_cmd = eca.pop_front();
          check("cmd_addr_a", ifa.cmd_addr, e_cmd[26:0]);
          check("cmd_len_a", ifa.cmd_len, e_cmd[31:27]);
        end
      end
      if (ifb.cmd_valid && ifb.cmd_ready) begin
        if (ecb.size() == 0) check("cmd_b_unexpected", 1'b1, 1'b0);
        else begin
          e_cmd = ecb.pop_front();
          check("cmd_addr_b", ifb.cmd_addr, e_cmd[26:0]);
          check("cmd_len_b", ifb.cmd_len, e_cmd[31:27]);
        end
      end
      if (ifa.wdata_valid && ifa.wdata_ready) begin
        if (eba.size() == 0) check("beat_a_unexpected", 1'b1, 1'b0);
        else begin
          e_beat = eba.pop_front();
          check("beat_data_a", ifa.wdata, e_beat[63:0]);
          check("beat_last_a", ifa.wdata_last, e_beat[64]);
        end
      end
      if (ifb.wdata_valid && ifb.wdata_ready) begin
        if (ebb.size() == 0) check("beat_b_unexpected", 1'b1, 1'b0);
        else begin
          e_beat = ebb.pop_front();
          check("beat_data_b", ifb.wdata, e_beat[63:0]);
          check("beat_last_b", ifb.wdata_last, e_beat[64]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_idle(input string p);
    check({p, "_ack"}, ifa.ddr3_ack, 1'b0);
    check({p, "_cmd_valid"}, ifa.cmd_valid, 1'b0);
    check({p, "_wdata_valid"}, ifa.wdata_valid, 1'b0);
    check({p, "_wdata_last"}, ifa.wdata_last, 1'b0);
    check({p, "_busy"}, ifa.busy, 1'b0);
    check({p, "_done"}, ifa.done, 1'b0);
    check({p, "_cmd_addr"}, ifa.cmd_addr, 27'h0);
    check({p, "_cmd_len"}, ifa.cmd_len, 5'h0);
    check({p, "_wdata"}, ifa.wdata, 64'h0);
    check({p, "_word_count"}, ifa.word_count, 32'h0);
    check({p, "_busy_b"}, ifb.busy, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    check("busy_before_start", ifa.busy, 1'b0);
    tick();
    start = 1'b0;
    @(negedge sys_clk);
    check("busy_after_start", ifa.busy, 1'b1);
    tick();
  endtask

  task automatic feed(input int n, input int budget, output int got);
    got = 0;
    valid = 1'b1;
    data = tag + 64'(sent);
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge sys_clk);
      if (ifa.ddr3_ack) begin
        got++;
        sent++;
      end
      tick();
      data = tag + 64'(sent);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (eba.size() == 0 && ebb.size() == 0) break;
      @(negedge sys_clk);
    end
    check("drain_in_time", (eba.size() == 0 && ebb.size() == 0), 1'b1);
    tick();
  endtask

  task automatic finish_frame(input int budget);
    int seen;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge sys_clk);
      if (ifa.done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", seen, 1);
    tick();
    @(negedge sys_clk);
    check("busy_low_after_done", ifa.busy, 1'b0);
    check("busy_b_low_after_done", ifb.busy, 1'b0);
    tick();
    check("cmds_left", eca.size() + ecb.size(), 0);
    check("beats_left", eba.size() + ebb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int dn;
    int found;

    // Reset, then IDLE must ignore a presented word.
    valid = 1'b1;
    data  = 64'hDEAD;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    @(negedge sys_clk);
    check_idle("rst_release");
    repeat (3) tick();
    @(negedge sys_clk);
    check_idle("idle_hold");
    valid = 1'b0;
    tick();

    // Single full burst, then flush with an empty FIFO.
    tag = 64'h0;
    sent = 0;
    model_frame(8, tag);
    check("model_a_cmd0", eca[0], {5'd8, 27'h0});
    check("model_b_cmd0", ecb[0], {5'd8, 27'h7FFFFC0});
    check("model_beat7", eba[7], {1'b1, 64'h7});
    check("model_beat6_not_last", eba[6][64], 1'b0);
    pulse_start();
    feed(8, 40, got);
    valid = 1'b0;
    check("full_feed_count", got, 8);
    @(negedge sys_clk);
    check("cmd_valid_latency", ifa.cmd_valid, 1'b1);
    check("word_count_8", ifa.word_count, 32'd8);
    tick();
    wait_drain(40);
    flush = 1'b1;
    @(negedge sys_clk);
    check("done_f0", ifa.done, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge sys_clk);
    check("done_f1", ifa.done, 1'b0);
    tick();
    @(negedge sys_clk);
    check("done_f2", ifa.done, 1'b1);
    check("busy_f2", ifa.busy, 1'b1);
    tick();
    @(negedge sys_clk);
    check("done_f3", ifa.done, 1'b0);
    check("busy_f3", ifa.busy, 1'b0);
    tick();

    // Backpressure: beats stalled, 16 acks fill the FIFO, release resumes acks one cycle after the first pop.
    tag = 64'h1000;
    sent = 0;
    model_frame(20, tag);
    check("model_a_cmd2", eca[2], {5'd4, 27'h80});
    wdata_ready = 1'b0;
    pulse_start();
    valid = 1'b1;
    data = tag;
    got = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (ifa.ddr3_ack) begin
        got++;
        sent++;
      end
      tick();
      data = tag + 64'(sent);
    end
    check("bp_ack_count", got, 16);
    wdata_ready = 1'b1;
    @(negedge sys_clk);
    check("bp_ack_on_first_pop", ifa.ddr3_ack, 1'b0);
    check("bp_beat_presented", ifa.wdata_valid, 1'b1);
    tick();
    @(negedge sys_clk);
    check("bp_ack_resume", ifa.ddr3_ack, 1'b1);
    if (ifa.ddr3_ack) sent++;
    tick();
    feed(20 - sent, 60, got);
    valid = 1'b0;
    check("bp_total_words", sent, 20);
    finish_frame(80);

    // Partial flush: 3 words, valid stays high afterwards, no more acks.
    tag = 64'h2000;
    sent = 0;
    model_frame(3, tag);
    check("model_partial", eca[0], {5'd3, 27'h0});
    pulse_start();
    feed(3, 20, got);
    check("pf_feed_count", got, 3);
    valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b1;
    data = tag + 64'(sent);
    got = 0;
    dn = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (ifa.ddr3_ack) got++;
      if (ifa.done) dn++;
      tick();
    end
    check("pf_no_ack", got, 0);
    check("pf_done_once", dn, 1);
    @(negedge sys_clk);
    check("pf_busy_low", ifa.busy, 1'b0);
    check("pf_word_count", ifa.word_count, 32'd3);
    valid = 1'b0;
    tick();
    check("pf_queues_empty", eca.size() + eba.size() + ecb.size() + ebb.size(), 0);

    // Two full bursts: second address steps by 0x40, wrapping on the high-base instance.
    tag = 64'h3000;
    sent = 0;
    model_frame(16, tag);
    check("model_b_wrap0", ecb[0][26:0], 27'h7FFFFC0);
    check("model_b_wrap1", ecb[1][26:0], 27'h0);
    check("model_a_step", eca[1][26:0], 27'h40);
    pulse_start();
    feed(16, 60, got);
    valid = 1'b0;
    check("wrap_feed_count", got, 16);
    @(negedge sys_clk);
    check("word_count_16", ifa.word_count, 32'd16);
    tick();
    finish_frame(80);

    // Reset during beat 4, then a clean burst at the base address.
    tag = 64'h4000;
    sent = 0;
    model_frame(8, tag);
    pulse_start();
    feed(8, 40, got);
    valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (ifa.wdata_valid) begin
        found = 1;
        break;
      end
    end
    check("rm_first_beat", found, 1);
    repeat (3) @(posedge sys_clk);
    #2 rst = 1'b1;
    #1 check_idle("rst_async");
    eca.delete();
    ecb.delete();
    eba.delete();
    ebb.delete();
    tick();
    rst = 1'b0;
    @(negedge sys_clk);
    check_idle("after_mid_rst");
    tick();
    tag = 64'h5000;
    sent = 0;
    model_frame(8, tag);
    pulse_start();
    feed(8, 40, got);
    valid = 1'b0;
    check("rm_feed_count", got, 8);
    wait_drain(40);
    finish_frame(40);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
